// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates fetch and data requests onto a single-port
// fixed-latency RAM, returns registered hit pulses, tracks an LL/SC reservation.
module mem_responder #(
  parameter int LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  logic [1:0]  state;
  logic [3:0]  count;
  logic        op_data;
  logic        op_write;
  logic        op_atomic;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resv_valid;
  logic [29:0] resv_addr;
  logic        sc_match;

  assign sc_match = resv_valid && (resv_addr == dmemaddr[31:2]);

  // Writes strobe only in the final busy cycle so a reset mid-access never commits
  assign ramREN   = (state == BUSY) && !op_write;
  assign ramWEN   = (state == BUSY) && op_write && (count == 4'd0);
  assign ramaddr  = (state == BUSY) ? addr : 32'd0;
  assign ramstore = ramWEN ? store_data : 32'd0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      count      <= 4'd0;
      op_data    <= 1'b0;
      op_write   <= 1'b0;
      op_atomic  <= 1'b0;
      addr       <= 32'd0;
      store_data <= 32'd0;
      resv_valid <= 1'b0;
      resv_addr  <= 30'd0;
      ihit       <= 1'b0;
      imemload   <= 32'd0;
      dhit       <= 1'b0;
      dmemload   <= 32'd0;
      flushed    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (halt) begin
            state   <= HALTED;
            flushed <= 1'b1;
          end else if (dmemREN || dmemWEN) begin
            op_data    <= 1'b1;
            op_write   <= dmemWEN;
            op_atomic  <= datomic;
            addr       <= dmemaddr;
            store_data <= dmemstore;
            // A failing SC never touches the RAM and answers immediately
            if (dmemWEN && datomic && !sc_match) begin
              state      <= RESP;
              dhit       <= 1'b1;
              dmemload   <= 32'd0;
              resv_valid <= 1'b0;
            end else begin
              state <= BUSY;
              count <= LAT_M1;
            end
          end else if (imemREN) begin
            op_data   <= 1'b0;
            op_write  <= 1'b0;
            op_atomic <= 1'b0;
            addr      <= imemaddr;
            state     <= BUSY;
            count     <= LAT_M1;
          end
        end
        BUSY: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            state <= RESP;
            if (!op_data) begin
              ihit     <= 1'b1;
              imemload <= ramload;
            end else if (op_write) begin
              dhit     <= 1'b1;
              dmemload <= {31'd0, op_atomic};
              if (op_atomic || (resv_addr == addr[31:2]))
                resv_valid <= 1'b0;
            end else begin
              dhit     <= 1'b1;
              dmemload <= ramload;
              if (op_atomic) begin
                resv_valid <= 1'b1;
                resv_addr  <= addr[31:2];
              end
            end
          end
        end
        RESP: begin
          ihit  <= 1'b0;
          dhit  <= 1'b0;
          state <= IDLE;
        end
        HALTED: begin
          flushed <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
